controle_principal_multiciclo: RTL and testbench

//  Multicycle main control FSM for the RV32 subset (lh, sh, add/sub/or/srl, andi, beq).

---
 rtl/controle_principal_multiciclo_if.sv | 34 +++
 rtl/controle_principal_multiciclo.sv | 186 ++++++++++++++++++
 tb/tb_controle_principal_multiciclo.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_principal_multiciclo_if.sv
// Control bundle between the multicycle main controller and its datapath.
// master = controller side, slave = datapath side.
interface controle_principal_multiciclo_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic [1:0]       imm_src;
  logic             illegal_instr;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, reg_write, imm_src, illegal_instr, retired
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, reg_write, imm_src, illegal_instr, retired
  );
endinterface

// File: rtl/controle_principal_multiciclo.sv
// Multicycle main control FSM for the RV32 subset lh, sh, add/sub/or/srl, andi, beq.
//  state      | meaning
//  S_FETCH    | read instruction at PC, PC+4 into PC on mem_ready
//  S_DECODE   | read registers, branch target into ALUOut
//  S_MEMADR   | rs1 + imm address for lh/sh
//  S_MEMREAD  | load access, wait for mem_ready
//  S_MEMWB    | write load data to rd
//  S_MEMWRITE | store access, strobe held until mem_ready
//  S_EXEC_R   | R-type ALU op, funct decoded downstream
//  S_EXEC_I   | andi
//  S_ALUWB    | write ALUOut to rd
//  S_BEQ      | compare rs1/rs2, load branch target on zero
//  S_ILLEGAL  | unsupported instruction, parked until reset
module controle_principal_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  controle_principal_multiciclo_if.master bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BEQ,
    S_ILLEGAL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             retire;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_nxt = S_ILLEGAL;
        case (bus.opcode)
          OP_LOAD:  if (bus.funct3 == 3'b001) state_nxt = S_MEMADR;
          OP_STORE: if (bus.funct3 == 3'b001) state_nxt = S_MEMADR;
          OP_RTYPE: state_nxt = S_EXEC_R;
          OP_IMM:   if (bus.funct3 == 3'b111) state_nxt = S_EXEC_I;
          OP_BRNCH: if (bus.funct3 == 3'b000) state_nxt = S_BEQ;
          default:  state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LOAD) begin
          state_nxt = S_MEMREAD;
        end else if (bus.opcode == OP_STORE) begin
          state_nxt = S_MEMWRITE;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_MEMREAD:  state_nxt = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_nxt = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R:   state_nxt = S_ALUWB;
      S_EXEC_I:   state_nxt = S_ALUWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Moore outputs are forced low during reset so an aborted access never strobes.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.reg_write  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          bus.adr_src = 1'b1;
        end
        S_MEMWB: begin
          bus.result_src = 2'b01;
          bus.reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          bus.adr_src   = 1'b1;
          bus.mem_write = 1'b1;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 2'b10;
          bus.alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
          bus.alu_op    = 2'b11;
        end
        S_ALUWB: begin
          bus.reg_write = 1'b1;
        end
        S_BEQ: begin
          bus.alu_src_a = 2'b10;
          bus.alu_op    = 2'b01;
          bus.pc_write  = bus.zero;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.opcode)
      OP_STORE: bus.imm_src = 2'b01;
      OP_BRNCH: bus.imm_src = 2'b10;
      default:  bus.imm_src = 2'b00;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (state == S_MEMWB || state == S_ALUWB || state == S_BEQ) begin
      retire = 1'b1;
    end else if (state == S_MEMWRITE && bus.mem_ready) begin
      retire = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (state == S_DECODE && state_nxt == S_ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign bus.retired       = retired_q;
  assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_controle_principal_multiciclo.sv
// Directed bench for the multicycle main controller: per-state control words,
// stalls, branches, illegal trap, reset abort and retirement count.
module tb_controle_principal_multiciclo;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ret = 32'd0;

  controle_principal_multiciclo_if #(.CNT_W(32)) bus ();
  controle_principal_multiciclo #(.CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Control word: pc_write adr_src mem_write ir_write result_src alu_src_a alu_src_b alu_op reg_write
  logic [12:0] ctl;
  assign ctl = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write};

  localparam logic [12:0] C_ZERO     = 13'b0_0_0_0_00_00_00_00_0;
  localparam logic [12:0] C_FETCH    = 13'b1_0_0_1_10_00_10_00_0;
  localparam logic [12:0] C_FETCH_W  = 13'b0_0_0_0_10_00_10_00_0;
  localparam logic [12:0] C_DECODE   = 13'b0_0_0_0_00_01_01_00_0;
  localparam logic [12:0] C_MEMADR   = 13'b0_0_0_0_00_10_01_00_0;
  localparam logic [12:0] C_MEMREAD  = 13'b0_1_0_0_00_00_00_00_0;
  localparam logic [12:0] C_MEMWB    = 13'b0_0_0_0_01_00_00_00_1;
  localparam logic [12:0] C_MEMWRITE = 13'b0_1_1_0_00_00_00_00_0;
  localparam logic [12:0] C_EXEC_R   = 13'b0_0_0_0_00_10_00_10_0;
  localparam logic [12:0] C_EXEC_I   = 13'b0_0_0_0_00_10_01_11_0;
  localparam logic [12:0] C_ALUWB    = 13'b0_0_0_0_00_00_00_00_1;
  localparam logic [12:0] C_BEQ0     = 13'b0_0_0_0_00_10_00_01_0;
  localparam logic [12:0] C_BEQ1     = 13'b1_0_0_0_00_10_00_01_0;

  task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic mr);
    @(negedge clk);
    reset = rst;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.zero = z;
    bus.mem_ready = mr;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 7'h03, 3'd1, 1'b1, 1'b1);
    checks++;
    if (ctl !== C_ZERO) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO);
    end
    step(1'b1, 7'h03, 3'd1, 1'b1, 1'b1);
    checks++;
    if (bus.retired !== 32'd0 || bus.illegal_instr !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs got retired=%0d illegal=%b exp 0/0", bus.retired, bus.illegal_instr);
    end
  endtask

  task automatic test_lh();
    logic [12:0] exp [5];
    exp = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMREAD, C_MEMWB};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 7'h03, 3'd1, 1'b0, 1'b1);
      checks++;
      if (ctl !== exp[i]) begin
        failures++;
        $display("FAIL lh_ctl cyc=%0d got=%b exp=%b", i, ctl, exp[i]);
      end
      checks++;
      if (bus.retired !== exp_ret) begin
        failures++;
        $display("FAIL lh_retired cyc=%0d got=%0d exp=%0d", i, bus.retired, exp_ret);
      end
      if (i == 0) begin
        checks++;
        if (bus.imm_src !== 2'b00) begin
          failures++;
          $display("FAIL lh_imm got=%b exp=00", bus.imm_src);
        end
      end
    end
    exp_ret++;
  endtask

  task automatic test_sh_stall();
    logic [12:0] exp [8];
    logic [7:0] mr_v;
    int mw_cnt;
    int rw_cnt;
    exp = '{C_FETCH_W, C_FETCH, C_DECODE, C_MEMADR, C_MEMWRITE, C_MEMWRITE, C_MEMWRITE, C_MEMWRITE};
    mr_v = 8'b1000_1110;
    mw_cnt = 0;
    rw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 7'h23, 3'd1, 1'b0, mr_v[i]);
      checks++;
      if (ctl !== exp[i]) begin
        failures++;
        $display("FAIL sh_ctl cyc=%0d got=%b exp=%b", i, ctl, exp[i]);
      end
      checks++;
      if (bus.retired !== exp_ret) begin
        failures++;
        $display("FAIL sh_retired cyc=%0d got=%0d exp=%0d", i, bus.retired, exp_ret);
      end
      if (bus.mem_write === 1'b1) mw_cnt++;
      if (bus.reg_write === 1'b1) rw_cnt++;
    end
    checks++;
    if (bus.imm_src !== 2'b01) begin
      failures++;
      $display("FAIL sh_imm got=%b exp=01", bus.imm_src);
    end
    checks++;
    if (mw_cnt != 4 || rw_cnt != 0) begin
      failures++;
      $display("FAIL sh_strobes got mem_write=%0d reg_write=%0d exp 4/0", mw_cnt, rw_cnt);
    end
    exp_ret++;
  endtask

  task automatic test_beq();
    logic [12:0] exp [3];
    for (int k = 0; k < 2; k++) begin
      logic z;
      z = (k == 0);
      exp = '{C_FETCH, C_DECODE, z ? C_BEQ1 : C_BEQ0};
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 7'h63, 3'd0, z, 1'b1);
        checks++;
        if (ctl !== exp[i]) begin
          failures++;
          $display("FAIL beq_ctl zero=%b cyc=%0d got=%b exp=%b", z, i, ctl, exp[i]);
        end
        checks++;
        if (bus.retired !== exp_ret) begin
          failures++;
          $display("FAIL beq_retired cyc=%0d got=%0d exp=%0d", i, bus.retired, exp_ret);
        end
      end
      checks++;
      if (bus.imm_src !== 2'b10) begin
        failures++;
        $display("FAIL beq_imm got=%b exp=10", bus.imm_src);
      end
      exp_ret++;
    end
  endtask

  task automatic test_alu();
    logic [12:0] exp [4];
    logic [6:0] op;
    logic [2:0] f3;
    for (int k = 0; k < 3; k++) begin
      op = (k == 0) ? 7'h13 : 7'h33;
      f3 = (k == 0) ? 3'd7 : ((k == 1) ? 3'd5 : 3'd0);
      exp = '{C_FETCH, C_DECODE, (k == 0) ? C_EXEC_I : C_EXEC_R, C_ALUWB};
      for (int i = 0; i < 4; i++) begin
        step(1'b0, op, f3, 1'b0, 1'b1);
        checks++;
        if (ctl !== exp[i]) begin
          failures++;
          $display("FAIL alu_ctl op=%h cyc=%0d got=%b exp=%b", op, i, ctl, exp[i]);
        end
        checks++;
        if (bus.retired !== exp_ret) begin
          failures++;
          $display("FAIL alu_retired cyc=%0d got=%0d exp=%0d", i, bus.retired, exp_ret);
        end
      end
      exp_ret++;
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp [3];
    exp = '{C_FETCH, C_DECODE, C_MEMADR};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 7'h23, 3'd1, 1'b0, 1'b1);
      checks++;
      if (ctl !== exp[i] || bus.retired !== exp_ret) begin
        failures++;
        $display("FAIL rmid_pre cyc=%0d got=%b/%0d exp=%b/%0d", i, ctl, bus.retired, exp[i], exp_ret);
      end
    end
    step(1'b0, 7'h23, 3'd1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_MEMWRITE) begin
      failures++;
      $display("FAIL rmid_memwrite got=%b exp=%b", ctl, C_MEMWRITE);
    end
    step(1'b1, 7'h23, 3'd1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_ZERO) begin
      failures++;
      $display("FAIL rmid_abort got=%b exp=%b", ctl, C_ZERO);
    end
    exp_ret = 32'd0;
    step(1'b0, 7'h23, 3'd1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_FETCH_W || bus.retired !== exp_ret || bus.illegal_instr !== 1'b0) begin
      failures++;
      $display("FAIL rmid_after got=%b/%0d/%b exp=%b/0/0", ctl, bus.retired, bus.illegal_instr, C_FETCH_W);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) step(1'b0, 7'h63, 3'd0, 1'b0, 1'b1);
    exp_ret++;
    step(1'b0, 7'h37, 3'd0, 1'b0, 1'b1);
    step(1'b0, 7'h37, 3'd0, 1'b0, 1'b1);
    checks++;
    if (ctl !== C_DECODE || bus.illegal_instr !== 1'b0 || bus.retired !== exp_ret) begin
      failures++;
      $display("FAIL ill_decode got=%b/%b/%0d exp=%b/0/%0d", ctl, bus.illegal_instr, bus.retired, C_DECODE, exp_ret);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 7'h37, 3'd0, 1'b1, 1'b1);
      checks++;
      if (ctl !== C_ZERO || bus.illegal_instr !== 1'b1 || bus.retired !== exp_ret) begin
        failures++;
        $display("FAIL ill_hold cyc=%0d got=%b/%b/%0d exp=%b/1/%0d", i, ctl, bus.illegal_instr, bus.retired, C_ZERO, exp_ret);
      end
    end
    step(1'b1, 7'h13, 3'd0, 1'b0, 1'b1);
    exp_ret = 32'd0;
    step(1'b0, 7'h13, 3'd0, 1'b0, 1'b1);
    checks++;
    if (ctl !== C_FETCH || bus.illegal_instr !== 1'b0 || bus.retired !== exp_ret) begin
      failures++;
      $display("FAIL ill_cleared got=%b/%b/%0d exp=%b/0/0", ctl, bus.illegal_instr, bus.retired, C_FETCH);
    end
    step(1'b0, 7'h13, 3'd0, 1'b0, 1'b1);
    step(1'b0, 7'h13, 3'd0, 1'b0, 1'b1);
    checks++;
    if (ctl !== C_ZERO || bus.illegal_instr !== 1'b1) begin
      failures++;
      $display("FAIL ill_addi got=%b/%b exp=%b/1", ctl, bus.illegal_instr, C_ZERO);
    end
    step(1'b1, 7'h00, 3'd0, 1'b0, 1'b0);
    step(1'b0, 7'h00, 3'd0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_FETCH_W || bus.illegal_instr !== 1'b0) begin
      failures++;
      $display("FAIL ill_final_reset got=%b/%b exp=%b/0", ctl, bus.illegal_instr, C_FETCH_W);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 7'h00;
    bus.funct3 = 3'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lh();
    test_sh_stall();
    test_beq();
    test_alu();
    test_reset_mid();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
